// File: rtl/m41_arb_pkg.sv
// Shared constants, FSM encoding and pointer-advance helper for the 4-way round-robin arbiter.
// Pure declarations: no latency and no flow control of its own.
package m41_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Advance the priority pointer one requester, wrapping the last one back to zero.
  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] ptr);
    return (ptr == SEL_W'(NUM_REQ - 1)) ? '0 : ptr + SEL_W'(1);
  endfunction

endpackage

// File: rtl/m41_rr_arbiter_rr_pick4.sv
// Rotate-priority picker: first valid requester searching ptr, ptr+1, ... modulo 4.
// Purely combinational (zero latency); no flow control of its own.
module rr_pick4
  import m41_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] in_valid,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  logic [SEL_W-1:0] w_cand;

  // The 2-bit candidate wraps naturally, giving the modulo-4 search order.
  always_comb begin
    idx    = ptr;
    any    = 1'b0;
    w_cand = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = ptr + SEL_W'(k);
      if (!any && in_valid[w_cand]) begin
        idx = w_cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m41_rr_arbiter.sv
// Round-robin packet arbiter driving a 4:1 mux select; owner keeps the grant until in_last.
// One bubble per grant, accepted beat on out_* 1 cycle later; in_ready drops while out is held.
module m41_rr_arbiter
  import m41_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  input  logic [NUM_REQ-1:0]        in_last,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          sel,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SEL_W-1:0]    r_ptr;
  logic [SEL_W-1:0]    r_sel;
  logic [NUM_REQ-1:0]  r_grant;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;

  logic [SEL_W-1:0]    w_pick_idx;
  logic                w_pick_any;
  logic                w_out_free;
  logic                w_accept;
  logic [DATA_W-1:0]   w_beat_data;
  logic                w_beat_last;

  rr_pick4 u_pick (
    .in_valid (in_valid),
    .ptr      (r_ptr),
    .idx      (w_pick_idx),
    .any      (w_pick_any)
  );

  // Output register can take a beat when empty or draining this cycle.
  assign w_out_free  = !r_out_valid || out_ready;
  assign w_beat_data = in_data[int'(r_sel)*DATA_W +: DATA_W];
  assign w_beat_last = in_last[r_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_any) w_state_nxt = BUSY;
      BUSY:    if (w_accept && w_beat_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = '0;
    busy     = 1'b0;
    w_accept = 1'b0;
    if (r_state == BUSY) begin
      busy            = 1'b1;
      in_ready[r_sel] = w_out_free;
      w_accept        = w_out_free && in_valid[r_sel];
    end
  end

  // sel is deliberately left alone on packet end so the mux keeps its last path in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_sel   <= '0;
      r_grant <= '0;
    end else if (r_state == IDLE && w_pick_any) begin
      r_sel   <= w_pick_idx;
      r_grant <= NUM_REQ'(1) << w_pick_idx;
    end else if (w_accept && w_beat_last) begin
      r_ptr   <= rr_next(r_sel);
      r_grant <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_beat_data;
      r_out_last  <= w_beat_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign sel       = r_sel;
  assign grant     = r_grant;

endmodule
